// File: rtl/sdram_cmd_arbiter_n.sv
// rtl/sdram_cmd_arbiter_n.sv - N-channel SDRAM command arbiter (sticky round-robin or fixed priority)
// Merges NUM_CH request streams into one registered valid/ready command stream.
package sdram_pkg;
  localparam int SDRAM_ADDR_W = 24;
  localparam int SDRAM_DATA_W = 32;
  localparam logic READ_CMD  = 1'b0;
  localparam logic WRITE_CMD = 1'b1;

  typedef struct packed {
    logic                    rw;
    logic [SDRAM_ADDR_W-1:0] addr;
    logic [SDRAM_DATA_W-1:0] wdata;
    logic                    auto_precharge_en;
  } sdram_cmd_t;
endpackage

module sdram_cmd_arbiter_n #(
  parameter int    NUM_CH        = 4,
  parameter int    ADDR_WIDTH    = 24,
  parameter string PRIORITY_MODE = "ROUND_ROBIN",
  parameter int    MAX_HOLD      = 1,
  localparam int   CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int   HOLD_W        = $clog2(MAX_HOLD + 1)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NUM_CH-1:0]            req_valid,
  output logic [NUM_CH-1:0]            req_ready,
  input  logic [NUM_CH-1:0]            req_we,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr,
  output logic                         cmd_valid,
  input  logic                         cmd_ready,
  output sdram_pkg::sdram_cmd_t        cmd_data,
  output logic [CH_W-1:0]              cmd_ch
);
  localparam bit IS_FIXED = (PRIORITY_MODE == "FIXED");
  localparam logic [CH_W:0]   NUM_CH_V   = (CH_W + 1)'(NUM_CH);
  localparam logic [HOLD_W:0] MAX_HOLD_V = (HOLD_W + 1)'(MAX_HOLD);

  logic [CH_W-1:0]         prio_ptr;
  logic [HOLD_W-1:0]       hold_cnt;
  logic [2*NUM_CH-1:0]     valid_dbl;
  logic [NUM_CH-1:0]       valid_rot;
  logic [NUM_CH-1:0]       grant_onehot;
  logic [CH_W-1:0]         grant_off;
  logic [CH_W-1:0]         grant_idx;
  logic [CH_W:0]           grant_sum;
  logic [CH_W:0]           grant_p1;
  logic [CH_W-1:0]         next_ptr_rot;
  logic [HOLD_W-1:0]       h_cur;
  logic [HOLD_W:0]         h_inc;
  logic                    grant_any;
  logic                    out_free;
  logic                    xfer;
  logic                    contention;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  sdram_pkg::sdram_cmd_t   load_cmd;

  // Circular search: rotate the doubled valid vector so prio_ptr lands at bit 0.
  // FIXED mode keeps prio_ptr at 0, so the same search yields the lowest index.
  always_comb begin
    valid_dbl = {req_valid, req_valid};
    valid_rot = NUM_CH'(valid_dbl >> prio_ptr);
    grant_any = 1'b0;
    grant_off = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        grant_any = 1'b1;
        grant_off = CH_W'(k);
      end
    end
    grant_sum = {1'b0, prio_ptr} + {1'b0, grant_off};
    grant_idx = (grant_sum >= NUM_CH_V) ? CH_W'(grant_sum - NUM_CH_V) : CH_W'(grant_sum);
    grant_onehot = NUM_CH'(1) << grant_idx;
    contention = |(req_valid & ~grant_onehot);

    out_free  = !cmd_valid || cmd_ready;
    xfer      = grant_any && out_free;
    req_ready = xfer ? grant_onehot : '0;

    sel_addr = ADDR_WIDTH'(req_addr >> (int'(grant_idx) * ADDR_WIDTH));
    load_cmd.rw                = |(req_we & grant_onehot);
    load_cmd.addr              = sdram_pkg::SDRAM_ADDR_W'(sel_addr);
    load_cmd.wdata             = '0;
    load_cmd.auto_precharge_en = 1'b1;

    // Hold count only carries over when the pointer channel keeps winning.
    h_cur        = (grant_idx == prio_ptr) ? hold_cnt : '0;
    h_inc        = {1'b0, h_cur} + 1'b1;
    grant_p1     = {1'b0, grant_idx} + 1'b1;
    next_ptr_rot = (grant_p1 >= NUM_CH_V) ? '0 : CH_W'(grant_p1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cmd_valid <= 1'b0;
      cmd_data  <= '0;
      cmd_ch    <= '0;
      prio_ptr  <= '0;
      hold_cnt  <= '0;
    end else if (xfer) begin
      cmd_valid <= 1'b1;
      cmd_data  <= load_cmd;
      cmd_ch    <= grant_idx;
      if (!IS_FIXED) begin
        if (contention && (h_inc >= MAX_HOLD_V)) begin
          prio_ptr <= next_ptr_rot;
          hold_cnt <= '0;
        end else if (contention) begin
          prio_ptr <= grant_idx;
          hold_cnt <= HOLD_W'(h_inc);
        end else begin
          prio_ptr <= grant_idx;
          hold_cnt <= h_cur;
        end
      end
    end else if (cmd_ready) begin
      cmd_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sdram_cmd_arbiter_n.sv
// tb/tb_sdram_cmd_arbiter_n.sv - self-checking bench for sdram_cmd_arbiter_n
// Four configurations share stimulus: RR hold 1, RR hold 3, FIXED, and 3-channel RR.
module tb_sdram_cmd_arbiter_n;
  import sdram_pkg::*;
  localparam int AW = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic [3:0]    req_valid;
  logic [3:0]    req_we;
  logic [AW-1:0] addr_in [4];
  logic [4*AW-1:0] req_addr;
  logic          cmd_ready;

  always_comb begin
    for (int k = 0; k < 4; k++) req_addr[k*AW +: AW] = addr_in[k];
  end

  logic [3:0] rdy_rr, rdy_hold, rdy_fix;
  logic [2:0] rdy_tri;
  logic       v_rr, v_hold, v_fix, v_tri;
  logic [1:0] ch_rr, ch_hold, ch_fix, ch_tri;
  sdram_cmd_t d_rr, d_hold, d_fix, d_tri;

  sdram_cmd_arbiter_n #(.NUM_CH(4), .ADDR_WIDTH(AW), .PRIORITY_MODE("ROUND_ROBIN"), .MAX_HOLD(1)) u_rr (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(rdy_rr), .req_we(req_we),
    .req_addr(req_addr), .cmd_valid(v_rr), .cmd_ready(cmd_ready), .cmd_data(d_rr), .cmd_ch(ch_rr));
  sdram_cmd_arbiter_n #(.NUM_CH(4), .ADDR_WIDTH(AW), .PRIORITY_MODE("ROUND_ROBIN"), .MAX_HOLD(3)) u_hold (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(rdy_hold), .req_we(req_we),
    .req_addr(req_addr), .cmd_valid(v_hold), .cmd_ready(cmd_ready), .cmd_data(d_hold), .cmd_ch(ch_hold));
  sdram_cmd_arbiter_n #(.NUM_CH(4), .ADDR_WIDTH(AW), .PRIORITY_MODE("FIXED"), .MAX_HOLD(1)) u_fix (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(rdy_fix), .req_we(req_we),
    .req_addr(req_addr), .cmd_valid(v_fix), .cmd_ready(cmd_ready), .cmd_data(d_fix), .cmd_ch(ch_fix));
  sdram_cmd_arbiter_n #(.NUM_CH(3), .ADDR_WIDTH(AW), .PRIORITY_MODE("ROUND_ROBIN"), .MAX_HOLD(1)) u_tri (
    .clk(clk), .rstn(rstn), .req_valid(req_valid[2:0]), .req_ready(rdy_tri), .req_we(req_we[2:0]),
    .req_addr(req_addr[3*AW-1:0]), .cmd_valid(v_tri), .cmd_ready(cmd_ready), .cmd_data(d_tri), .cmd_ch(ch_tri));

  logic [3:0] o_rdy [4];
  logic       o_vld [4];
  logic [1:0] o_ch  [4];
  sdram_cmd_t o_dat [4];
  always_comb begin
    o_rdy[0] = rdy_rr;  o_rdy[1] = rdy_hold; o_rdy[2] = rdy_fix; o_rdy[3] = {1'b0, rdy_tri};
    o_vld[0] = v_rr;    o_vld[1] = v_hold;   o_vld[2] = v_fix;   o_vld[3] = v_tri;
    o_ch[0]  = ch_rr;   o_ch[1]  = ch_hold;  o_ch[2]  = ch_fix;  o_ch[3]  = ch_tri;
    o_dat[0] = d_rr;    o_dat[1] = d_hold;   o_dat[2] = d_fix;   o_dat[3] = d_tri;
  end

  // Reference model: arbitration rules stated directly, per configuration.
  int  P_N  [4] = '{4, 4, 4, 3};
  bit  P_FIX[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  int  P_MH [4] = '{1, 3, 1, 1};
  bit         m_valid [4];
  int         m_ch    [4];
  int         m_ptr   [4];
  int         m_hold  [4];
  sdram_cmd_t m_dat   [4];

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int model_grant(input int i);
    int n;
    int c;
    n = P_N[i];
    for (int k = 0; k < n; k++) begin
      c = P_FIX[i] ? k : (m_ptr[i] + k) % n;
      if (req_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_ready(input int i);
    int g;
    g = model_grant(i);
    if (g >= 0 && (!m_valid[i] || cmd_ready)) return 4'(1 << g);
    return 4'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0; m_ch[i] = 0; m_ptr[i] = 0; m_hold[i] = 0; m_dat[i] = '0;
    end
  endtask

  task automatic model_update(input int i);
    int g, n, h;
    bit cont;
    n = P_N[i];
    g = model_grant(i);
    if (g >= 0 && (!m_valid[i] || cmd_ready)) begin
      m_valid[i] = 1'b1;
      m_ch[i] = g;
      m_dat[i].rw = req_we[g];
      m_dat[i].addr = addr_in[g];
      m_dat[i].wdata = '0;
      m_dat[i].auto_precharge_en = 1'b1;
      if (!P_FIX[i]) begin
        cont = 1'b0;
        for (int k = 0; k < n; k++) if (k != g && req_valid[k]) cont = 1'b1;
        h = (g == m_ptr[i]) ? m_hold[i] : 0;
        if (cont && h + 1 >= P_MH[i]) begin
          m_ptr[i] = (g + 1) % n; m_hold[i] = 0;
        end else if (cont) begin
          m_ptr[i] = g; m_hold[i] = h + 1;
        end else begin
          m_ptr[i] = g; m_hold[i] = h;
        end
      end
    end else if (cmd_ready) begin
      m_valid[i] = 1'b0;
    end
  endtask

  // Inputs are set at posedge+1; comb outputs are checked at posedge+2.
  task automatic step_pre();
    #1;
    for (int i = 0; i < 4; i++) chk($sformatf("req_ready[cfg%0d]", i), 64'(o_rdy[i]), 64'(model_ready(i)));
    if (!rstn) model_reset();
    else for (int i = 0; i < 4; i++) model_update(i);
  endtask

  task automatic step_post();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("cmd_valid[cfg%0d]", i), 64'(o_vld[i]), 64'(m_valid[i]));
      chk($sformatf("cmd_ch[cfg%0d]", i), 64'(o_ch[i]), 64'(m_ch[i]));
      chk($sformatf("cmd_data[cfg%0d]", i), 64'(o_dat[i]), 64'(m_dat[i]));
    end
    chk("tri_ptr_range", 64'(u_tri.prio_ptr <= 2'd2), 64'd1);
  endtask

  task automatic step();
    step_pre();
    step_post();
  endtask

  typedef struct {
    bit         rst;
    logic [3:0] v;
    logic [3:0] we;
    bit         ev;
    logic [1:0] e_rr, e_hold, e_fix, e_tri;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input bit rst, input logic [3:0] v, input bit ev,
                     input logic [1:0] er, input logic [1:0] eh, input logic [1:0] ef, input logic [1:0] et);
    vec_t r;
    r.rst = rst; r.v = v; r.we = 4'b1010; r.ev = ev;
    r.e_rr = er; r.e_hold = eh; r.e_fix = ef; r.e_tri = et;
    vecs.push_back(r);
  endtask

  initial begin
    logic [1:0] ech [4];
    vec_t r;

    // Power-up, reset with all channels valid, then the RR sequence.
    add(1, 4'hF, 0, 0, 0, 0, 0); add(1, 4'hF, 0, 0, 0, 0, 0); add(1, 4'hF, 0, 0, 0, 0, 0);
    add(0, 4'hF, 1, 0, 0, 0, 0); add(0, 4'hF, 1, 1, 0, 0, 1); add(0, 4'hF, 1, 2, 0, 0, 2);
    add(0, 4'hF, 1, 3, 1, 0, 0); add(0, 4'hF, 1, 0, 1, 0, 1); add(0, 4'hF, 1, 1, 1, 0, 2);
    // Mid-stream reset returns the next grant to channel 0.
    add(1, 4'hF, 0, 0, 0, 0, 0); add(0, 4'hF, 1, 0, 0, 0, 0);
    // Channels 1 and 2 contending, from a fresh pointer.
    add(1, 4'h6, 0, 0, 0, 0, 0);
    add(0, 4'h6, 1, 1, 1, 1, 1); add(0, 4'h6, 1, 2, 1, 1, 2); add(0, 4'h6, 1, 1, 1, 1, 1);
    add(0, 4'h6, 1, 2, 2, 1, 2); add(0, 4'h6, 1, 1, 2, 1, 1); add(0, 4'h6, 1, 2, 2, 1, 2);
    add(0, 4'h6, 1, 1, 1, 1, 1);
    // Lone requester on channel 2 is granted every cycle.
    for (int k = 0; k < 10; k++) add(0, 4'h4, 1, 2, 2, 2, 2);

    for (int k = 0; k < 4; k++) addr_in[k] = AW'(24'h100000 * (k + 1) + k);
    req_valid = '0; req_we = '0; cmd_ready = 1'b1; rstn = 1'b0;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;

    foreach (vecs[n]) begin
      r = vecs[n];
      rstn = !r.rst; req_valid = r.v; req_we = r.we; cmd_ready = 1'b1;
      step();
      ech[0] = r.e_rr; ech[1] = r.e_hold; ech[2] = r.e_fix; ech[3] = r.e_tri;
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("vec%0d valid cfg%0d", n, i), 64'(o_vld[i]), 64'(r.ev));
        chk($sformatf("vec%0d ch cfg%0d", n, i), 64'(o_ch[i]), 64'(ech[i]));
      end
      if (r.ev) begin
        chk($sformatf("vec%0d rw", n), 64'(o_dat[0].rw), 64'(r.we[r.e_rr]));
        chk($sformatf("vec%0d addr", n), 64'(o_dat[0].addr), 64'(addr_in[r.e_rr]));
      end
    end

    // Backpressure: held command stays put, all ready low, release reloads without a bubble.
    rstn = 1'b1; req_valid = 4'h1; addr_in[0] = 24'h00ABCD; cmd_ready = 1'b1;
    step();
    chk("bp_load_addr", 64'(o_dat[0].addr), 64'h00ABCD);
    req_valid = 4'hF; cmd_ready = 1'b0; addr_in[0] = 24'h00BEEF;
    for (int k = 0; k < 5; k++) begin
      step_pre();
      chk($sformatf("bp_ready%0d", k), 64'(rdy_rr), 64'd0);
      step_post();
      chk($sformatf("bp_hold_addr%0d", k), 64'(o_dat[0].addr), 64'h00ABCD);
      chk($sformatf("bp_hold_ch%0d", k), 64'(ch_rr), 64'd0);
    end
    req_valid = 4'hE; cmd_ready = 1'b1;
    step_pre();
    chk("bp_release_ready", 64'(rdy_rr), 64'h2);
    step_post();
    chk("bp_release_ch", 64'(ch_rr), 64'd1);
    chk("bp_release_valid", 64'(v_rr), 64'd1);

    // Fixed priority with channels 1 and 3.
    req_valid = 4'hA;
    for (int k = 0; k < 4; k++) begin
      step_pre();
      chk($sformatf("fix_ready%0d", k), 64'(rdy_fix), 64'h2);
      step_post();
      chk($sformatf("fix_ch%0d", k), 64'(ch_fix), 64'd1);
    end

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      rstn = ($urandom_range(0, 49) != 0);
      req_valid = 4'($urandom);
      req_we = 4'($urandom);
      cmd_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < 4; c++) addr_in[c] = AW'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sdram_cmd_arbiter_n.md
# sdram_cmd_arbiter_n

N-channel successor to the two-port SDRAM command arbiter. Merges `NUM_CH` request streams into the single command stream that feeds the SDRAM controller command FIFO. Each request carries its own read/write flag. Uses sticky round-robin with a bounded hold count, or fixed priority. The output is a registered valid/ready stage that accepts a new command every cycle.

## Interface
- `NUM_CH`, 4: number of request channels, ≥1.
- `ADDR_WIDTH`, 24: command address width.
- `PRIORITY_MODE`, "ROUND_ROBIN": "ROUND_ROBIN" or "FIXED" (lowest index wins).
- `MAX_HOLD`, 1: consecutive contended grants one channel may win before forced rotation, ≥1. Value 1 gives classic round-robin.
- `CH_W`, derived: `NUM_CH>1 ? $clog2(NUM_CH) : 1`.
- `clk  in  1`: the single clock. All logic is on its rising edge.
- `rstn  in  1`: reset, synchronous and active-low.
- `req_valid  in  NUM_CH`: per-channel request valid.
- `req_ready  out  NUM_CH`: per-channel accept. One-hot or zero.
- `req_we  in  NUM_CH`: per-channel write flag (1 = WRITE_CMD, 0 = READ_CMD).
- `req_addr  in  NUM_CH*ADDR_WIDTH`: channel k address at bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- `cmd_valid  out  1`: output command valid.
- `cmd_ready  in  1`: downstream accept.
- `cmd_data  out  sdram_pkg::sdram_cmd_t`: fields are rw, addr, wdata='0, auto_precharge_en=1.
- `cmd_ch  out  CH_W`: index of the channel that issued `cmd_data`.

## Operation
- `out_free = !cmd_valid || cmd_ready`.
- Transfer on channel g happens when `req_valid[g] && req_ready[g]`.
- **Grant selection (combinational):**
  - ROUND_ROBIN: g is the first valid channel in circular search starting at `prio_ptr`.
  - FIXED: g is the lowest valid index.
  - `req_ready[g] = out_free`. All other `req_ready` bits are 0.
  - There is a combinational path from `cmd_ready` to `req_ready`; this is intended.
- **Output register:**
  - On transfer: `cmd_valid<=1`, `cmd_data.rw<=req_we[g]`, `cmd_data.addr<=req_addr[g]`, `cmd_ch<=g`.
  - Else if `cmd_ready`: `cmd_valid<=0`, data unchanged.
  - While `cmd_valid && !cmd_ready`, `cmd_data` and `cmd_ch` are held stable.
- **Priority state (ROUND_ROBIN only), updated only on a transfer:**
  - Contention = any other channel valid in the same cycle.
  - `h = (g==prio_ptr) ? hold_cnt : 0`.
  - Contention and `h+1 >= MAX_HOLD`: `prio_ptr<=(g+1) mod NUM_CH`, `hold_cnt<=0`.
  - Contention otherwise: `prio_ptr<=g`, `hold_cnt<=h+1`.
  - No contention: `prio_ptr<=g`, `hold_cnt<=h`. A lone requester is never penalised.
- FIXED mode: `prio_ptr` and `hold_cnt` stay at 0.
- Widths:
  - `prio_ptr` is CH_W bits.
  - `hold_cnt` is `$clog2(MAX_HOLD+1)` bits.
  - Wrap-around from NUM_CH-1 goes to 0. For non-power-of-2 NUM_CH, the pointer never exceeds NUM_CH-1.
- NUM_CH=1: single pass-through register. `cmd_ch` is always 0.

## Timing
- Reset values: `cmd_valid=0`, `cmd_data='0` (rw=READ_CMD, addr 0), `cmd_ch=0`, `prio_ptr=0`, `hold_cnt=0`. `req_ready` follows combinationally (all 1-capable, since out_free=1).
- Reset asserted mid-operation discards any held command on the next edge. No partial state survives.
- Latency: request accepted at edge T appears with `cmd_valid=1` after edge T.
- Throughput: one command per cycle while `cmd_ready=1`.
- Backpressure: `cmd_valid=1, cmd_ready=0` forces all `req_ready=0`. Priority state is frozen.
- Requesters may drop `req_valid` without a transfer. Arbitration recomputes every cycle.
- Simultaneous `cmd_ready` and a new transfer in the same cycle: the register loads the new command with no bubble.

## Test plan
- **Reset:** `rstn=0` for 3 cycles with all channels valid. Then: `cmd_valid=0`, `cmd_ch=0`. First grant after release is ch0, `cmd_valid=1` one cycle later.
- **Round-robin:** NUM_CH=4, MAX_HOLD=1, all valid, `cmd_ready=1`. `cmd_ch` sequence is 0,1,2,3,0,1. `cmd_data.rw` matches each channel's `req_we`.
- **Sticky hold:** MAX_HOLD=3, ch1 and ch2 continuously valid, `prio_ptr` starting at 1. Grants are 1,1,1,2,2,2,1. With ch2 only valid, ch2 is granted every cycle for 10 cycles.
- **Backpressure:** `cmd_ready=0` for 5 cycles while holding addr 0x00ABCD. `cmd_data` is stable and `req_ready=0` throughout. Raising `cmd_ready` accepts the next request in the same cycle.
- **Fixed mode:** FIXED, ch3 and ch1 valid for 4 cycles. ch1 is granted every cycle and ch3 never.
- **Non-power-of-2:** NUM_CH=3, all valid. Grants 0,1,2,0. `prio_ptr` never reaches 3. Mid-stream reset returns the next grant to ch0.
